// File: rtl/pifo_param.sv
// Push-in first-out queue: per-flow FIFOs, smallest-rank head is dequeued.
// Define PIFO_PARAM_STATS_EN to enable occupancy and drop_count counters.
module pifo_param #(
    parameter int FLOWS  = 4,
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int RANK_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic [RANK_W-1:0]                  push_rank,
    input  logic [DATA_W-1:0]                  push_value,
    input  logic [$clog2(FLOWS)-1:0]           push_flow,
    output logic                               push_accept,
    input  logic                               pop,
    output logic                               pop_valid,
    output logic [DATA_W-1:0]                  pop_value,
    output logic [RANK_W-1:0]                  pop_rank,
    output logic [$clog2(FLOWS)-1:0]           pop_flow,
    output logic [FLOWS-1:0]                   flow_full,
    output logic [$clog2(FLOWS*DEPTH+1)-1:0]   occupancy,
    output logic [15:0]                        drop_count
);

    localparam int FW = $clog2(FLOWS);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(FLOWS*DEPTH+1);
    localparam int EW = RANK_W + DATA_W;
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0]     mem [FLOWS][DEPTH];
    logic [AW-1:0]     rd_ptr [FLOWS];
    logic [AW-1:0]     wr_ptr [FLOWS];
    logic [AW:0]       count [FLOWS];
    logic [FLOWS-1:0]  nonempty;
    logic [FLOWS-1:0]  wr_en;
    logic [FLOWS-1:0]  rd_en;
    logic              push_full;
    logic              do_pop;
    logic              found;
    logic [FW-1:0]     sel;
    logic [RANK_W-1:0] sel_rank;
    logic [DATA_W-1:0] sel_value;
    logic [EW-1:0]     head;

    always_comb begin
        for (int i = 0; i < FLOWS; i++) begin
            flow_full[i] = (count[i] == FULL);
            nonempty[i]  = (count[i] != '0);
        end
        pop_valid = |nonempty;
    end

    // Strict compare in index order keeps the lowest flow on rank ties.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_rank  = '0;
        sel_value = '0;
        head      = '0;
        for (int i = 0; i < FLOWS; i++) begin
            head = mem[i][rd_ptr[i]];
            if (nonempty[i] && (!found || head[EW-1:DATA_W] < sel_rank)) begin
                found     = 1'b1;
                sel       = FW'(i);
                sel_rank  = head[EW-1:DATA_W];
                sel_value = head[DATA_W-1:0];
            end
        end
        pop_flow  = sel;
        pop_rank  = sel_rank;
        pop_value = sel_value;
    end

    // Out-of-range flow indices match no flow and stay "full".
    always_comb begin
        push_full = 1'b1;
        for (int i = 0; i < FLOWS; i++) begin
            if (push_flow == FW'(i)) begin
                push_full = flow_full[i];
            end
        end
        push_accept = push & ~push_full;
        do_pop      = pop & pop_valid;
        for (int i = 0; i < FLOWS; i++) begin
            wr_en[i] = push_accept && (push_flow == FW'(i));
            rd_en[i] = do_pop && (sel == FW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FLOWS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < FLOWS; i++) begin
                if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (wr_en[i] && !rd_en[i]) count[i] <= count[i] + ONE;
                else if (rd_en[i] && !wr_en[i]) count[i] <= count[i] - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FLOWS; i++) begin
            if (wr_en[i]) mem[i][wr_ptr[i]] <= {push_rank, push_value};
        end
    end

`ifdef PIFO_PARAM_STATS_EN
    logic [OW-1:0] occ;
    logic [15:0]   drops;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ   <= '0;
            drops <= '0;
        end else begin
            occ <= occ + OW'(push_accept) - OW'(do_pop);
            if (push && !push_accept && drops != 16'hFFFF) begin
                drops <= drops + 16'd1;
            end
        end
    end

    assign occupancy  = occ;
    assign drop_count = drops;
`else
    assign occupancy  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pifo_param.sv
// Scoreboard bench for pifo_param with FLOWS=4, DEPTH=4.
// Stats outputs are checked against the model only when PIFO_PARAM_STATS_EN is set.
module tb_pifo_param;

`ifdef PIFO_PARAM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic [15:0] push_rank = '0;
    logic [31:0] push_value = '0;
    logic [1:0]  push_flow = '0;
    logic        push_accept;
    logic        pop = 1'b0;
    logic        pop_valid;
    logic [31:0] pop_value;
    logic [15:0] pop_rank;
    logic [1:0]  pop_flow;
    logic [3:0]  flow_full;
    logic [4:0]  occupancy;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [47:0] mq [4][$];
    int          exp_drop = 0;

    pifo_param #(.FLOWS(4), .DEPTH(4), .DATA_W(32), .RANK_W(16)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_rank(push_rank), .push_value(push_value),
        .push_flow(push_flow), .push_accept(push_accept),
        .pop(pop), .pop_valid(pop_valid), .pop_value(pop_value),
        .pop_rank(pop_rank), .pop_flow(pop_flow),
        .flow_full(flow_full), .occupancy(occupancy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic int model_occ();
        int s = 0;
        for (int f = 0; f < 4; f++) s += mq[f].size();
        return s;
    endfunction

    function automatic logic [3:0] model_full();
        logic [3:0] m = '0;
        for (int f = 0; f < 4; f++) m[f] = (mq[f].size() == 4);
        return m;
    endfunction

    // One clock of stimulus; scoreboard predicts and checks every output.
    task automatic drive_cycle(input bit p, input logic [1:0] f,
                               input logic [15:0] r, input logic [31:0] v,
                               input bit q, output logic [31:0] got_value,
                               output bit got_acc);
        bit          exp_acc;
        bit          exp_valid;
        int          sf;
        logic [47:0] hd;
        logic [4:0]  eo;
        logic [15:0] ed;
        push = p; push_flow = f; push_rank = r; push_value = v; pop = q;
        @(negedge clk);
        exp_acc   = p && (mq[f].size() < 4);
        exp_valid = (model_occ() != 0);
        sf = -1;
        for (int i = 0; i < 4; i++) begin
            if (mq[i].size() != 0) begin
                if (sf < 0 || mq[i][0][47:32] < mq[sf][0][47:32]) sf = i;
            end
        end
        checks++;
        if (push_accept !== exp_acc) begin
            errors++;
            $display("FAIL push_accept: got %b expected %b", push_accept, exp_acc);
        end
        checks++;
        if (pop_valid !== exp_valid) begin
            errors++;
            $display("FAIL pop_valid: got %b expected %b", pop_valid, exp_valid);
        end
        got_acc   = push_accept;
        got_value = pop_value;
        if (exp_valid) begin
            hd = mq[sf][0];
            checks++;
            if (pop_rank !== hd[47:32] || pop_value !== hd[31:0] || pop_flow !== 2'(sf)) begin
                errors++;
                $display("FAIL head: got f%0d r%0d v%h expected f%0d r%0d v%h",
                         pop_flow, pop_rank, pop_value, sf, hd[47:32], hd[31:0]);
            end
        end
        @(posedge clk);
        if (q && exp_valid) void'(mq[sf].pop_front());
        if (exp_acc) mq[f].push_back({r, v});
        else if (p && exp_drop != 16'hFFFF) exp_drop++;
        #1;
        push = 1'b0; pop = 1'b0;
        eo = STATS ? 5'(model_occ()) : 5'd0;
        ed = STATS ? 16'(exp_drop) : 16'd0;
        checks++;
        if (occupancy !== eo || drop_count !== ed || flow_full !== model_full()) begin
            errors++;
            $display("FAIL stats: got occ %0d drop %0d full %b expected occ %0d drop %0d full %b",
                     occupancy, drop_count, flow_full, eo, ed, model_full());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pop_valid !== 1'b0 || flow_full !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags: got valid %b full %b expected 0 0", pop_valid, flow_full);
        end
        checks++;
        if (occupancy !== 5'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: got occ %0d drop %0d expected 0 0", occupancy, drop_count);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rank_order();
        logic [31:0] gv;
        bit          ga;
        logic [31:0] want [3];
        want[0] = 32'hB; want[1] = 32'hA; want[2] = 32'hC;
        drive_cycle(1, 2'd0, 16'd5, 32'hA, 0, gv, ga);
        drive_cycle(1, 2'd1, 16'd3, 32'hB, 0, gv, ga);
        drive_cycle(1, 2'd2, 16'd5, 32'hC, 0, gv, ga);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
            checks++;
            if (gv !== want[i]) begin
                errors++;
                $display("FAIL rank_order[%0d]: got %h expected %h", i, gv, want[i]);
            end
        end
    endtask

    task automatic test_fifo_within_flow();
        logic [31:0] gv;
        bit          ga;
        drive_cycle(1, 2'd1, 16'd9, 32'h91, 0, gv, ga);
        drive_cycle(1, 2'd1, 16'd2, 32'h22, 0, gv, ga);
        @(negedge clk);
        checks++;
        if (pop_rank !== 16'd9) begin
            errors++;
            $display("FAIL fifo_first_rank: got %0d expected 9", pop_rank);
        end
        @(posedge clk);
        #1;
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
        checks++;
        if (gv !== 32'h22) begin
            errors++;
            $display("FAIL fifo_second: got %h expected 22", gv);
        end
    endtask

    task automatic test_full_drop();
        logic [31:0] gv;
        bit          ga;
        bit          want [5];
        want[0] = 1; want[1] = 1; want[2] = 1; want[3] = 1; want[4] = 0;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 2'd3, 16'(10 + i), 32'(16'h300 + i), 0, gv, ga);
            checks++;
            if (ga !== want[i]) begin
                errors++;
                $display("FAIL full_accept[%0d]: got %b expected %b", i, ga, want[i]);
            end
        end
        checks++;
        if (flow_full[3] !== 1'b1) begin
            errors++;
            $display("FAIL flow_full3: got %b expected 1", flow_full[3]);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] gv;
        bit          ga;
        drive_cycle(1, 2'd3, 16'd1, 32'h399, 1, gv, ga);
        checks++;
        if (ga !== 1'b0 || gv !== 32'h300) begin
            errors++;
            $display("FAIL full_push_pop: got acc %b val %h expected 0 300", ga, gv);
        end
        while (model_occ() != 0) drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
    endtask

    task automatic test_wrap();
        logic [31:0] gv;
        bit          ga;
        drive_cycle(1, 2'd0, 16'd4, 32'h1000, 0, gv, ga);
        for (int i = 1; i <= 12; i++) begin
            drive_cycle(1, 2'd0, 16'($urandom_range(0, 65535)), 32'(32'h1000 + i), 1, gv, ga);
            checks++;
            if (gv !== 32'(32'h1000 + i - 1)) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, gv, 32'h1000 + i - 1);
            end
        end
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
    endtask

    task automatic test_reset_mid();
        logic [31:0] gv;
        bit          ga;
        drive_cycle(1, 2'd0, 16'd8, 32'hD0, 0, gv, ga);
        drive_cycle(1, 2'd1, 16'd6, 32'hD1, 0, gv, ga);
        drive_cycle(1, 2'd2, 16'd7, 32'hD2, 0, gv, ga);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (pop_valid !== 1'b0 || occupancy !== 5'd0 || flow_full !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got valid %b occ %0d full %b expected 0 0 0",
                     pop_valid, occupancy, flow_full);
        end
        push = 1'b1; push_flow = 2'd2; push_rank = 16'd1; push_value = 32'hEE; pop = 1'b1;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
        for (int f = 0; f < 4; f++) mq[f].delete();
        exp_drop = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
        drive_cycle(1, 2'd1, 16'd7, 32'h77, 0, gv, ga);
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
        checks++;
        if (gv !== 32'h77) begin
            errors++;
            $display("FAIL reset_mid_new: got %h expected 77", gv);
        end
        drive_cycle(0, 2'd0, 16'd0, 32'd0, 1, gv, ga);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rank_order();
        test_fifo_within_flow();
        test_full_drop();
        test_full_push_pop();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
